// File: rtl/servo_pwm_array_if.sv
// Setpoint handshake bundle for servo_pwm_array: a packed set of signed angles
// offered by the joint-angle source under valid/ready.
interface servo_pwm_array_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ANG_W  = 10
);
  logic [NUM_CH*ANG_W-1:0] ang_flat;
  logic                    ang_valid;
  logic                    ang_ready;

  modport master (output ang_flat, output ang_valid, input ang_ready);
  modport slave  (input ang_flat, input ang_valid, output ang_ready);
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: sequential angle-to-duty conversion with
// clamp and hysteresis, period-aligned duty update. Optional SERVO_SLEW_EN limits duty slew.
module servo_pwm_array #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned PWM_FREQ  = 50,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ANG_W     = 10,
  parameter int          ANG_MAX   = 270,
  parameter int unsigned DC_MIN    = 25_000,
  parameter int unsigned DC_MID    = 75_000,
  parameter int unsigned DC_MAX    = 125_000,
  parameter int          HYST      = 15,
  parameter int unsigned SLEW_STEP = 5_000
) (
  input  logic               clk,
  input  logic               rst,
  servo_pwm_array_if.slave   ang,
  input  logic [NUM_CH-1:0]  enable,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start
);

  localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (DC_MAX >= PERIOD || SLEW_STEP == 0) begin : g_param_check
    $error("servo_pwm_array: DC_MAX must be below PERIOD and SLEW_STEP positive");
  end

  typedef enum logic {S_IDLE, S_CONV} state_e;

  state_e                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [NUM_CH*ANG_W-1:0] ang_q;
  logic signed [ANG_W:0]   last_q    [NUM_CH];
  logic [31:0]             pending_q [NUM_CH];
  logic [31:0]             target_q  [NUM_CH];
  logic [31:0]             target_d  [NUM_CH];
  logic [31:0]             duty_q    [NUM_CH];
  logic [31:0]             duty_d    [NUM_CH];
  logic [31:0]             cnt_q;
  logic                    ready_q;
  logic                    pstart_q;
  logic [NUM_CH-1:0]       pwm_q;

  logic signed [ANG_W-1:0] raw;
  int                      a_c;
  int                      diff;
  logic                    hold;
  logic [31:0]             mag;
  logic [31:0]             dc_new;
  logic [31:0]             conv_duty;
  logic                    commit;
  logic                    wrap;

  assign ang.ang_ready = ready_q;
  assign pwm_out       = pwm_q;
  assign period_start  = pstart_q;
  assign wrap          = (cnt_q == PERIOD - 1);

  always_comb begin
    raw = ang_q[ch_q*ANG_W +: ANG_W];
    a_c = int'(raw);
    if (a_c > ANG_MAX)       a_c = ANG_MAX;
    else if (a_c < -ANG_MAX) a_c = -ANG_MAX;
    diff = a_c - int'(last_q[ch_q]);
    if (diff < 0) diff = -diff;
    hold = (diff <= HYST);
    if (a_c >= 0) begin
      mag    = 32'(a_c);
      dc_new = DC_MID + ((DC_MAX - DC_MID) * mag) / 32'(ANG_MAX);
    end else begin
      mag    = 32'(-a_c);
      dc_new = DC_MID - ((DC_MID - DC_MIN) * mag) / 32'(ANG_MAX);
    end
    conv_duty = hold ? target_q[ch_q] : dc_new;
    commit    = (state_q == S_CONV) && (ch_q == CH_W'(NUM_CH - 1));
    // Last channel's result bypasses pending so the whole set commits in one cycle.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      target_d[i] = target_q[i];
      if (commit) target_d[i] = (i == NUM_CH - 1) ? conv_duty : pending_q[i];
`ifdef SERVO_SLEW_EN
      if (target_d[i] > duty_q[i])
        duty_d[i] = (target_d[i] - duty_q[i] > SLEW_STEP) ? duty_q[i] + SLEW_STEP : target_d[i];
      else
        duty_d[i] = (duty_q[i] - target_d[i] > SLEW_STEP) ? duty_q[i] - SLEW_STEP : target_d[i];
`else
      duty_d[i] = target_d[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      ang_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      pstart_q <= 1'b0;
      pwm_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        last_q[i]    <= '0;
        pending_q[i] <= DC_MID;
        target_q[i]  <= DC_MID;
        duty_q[i]    <= DC_MID;
      end
    end else begin
      cnt_q    <= wrap ? '0 : cnt_q + 32'd1;
      pstart_q <= (cnt_q == '0);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pwm_q[i]    <= enable[i] && (cnt_q < duty_q[i]);
        target_q[i] <= target_d[i];
        if (wrap) duty_q[i] <= duty_d[i];
      end
      case (state_q)
        S_IDLE: begin
          if (ang.ang_valid && ready_q) begin
            ang_q   <= ang.ang_flat;
            ch_q    <= '0;
            ready_q <= 1'b0;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          pending_q[ch_q] <= conv_duty;
          if (!hold) last_q[ch_q] <= a_c[ANG_W:0];
          if (commit) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array with a shortened period (2000 cycles) and
// duty counts scaled to 250/750/1250; expected high times are hand-computed.
module tb_servo_pwm_array;

  localparam int PERIOD = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] pwm_out;
  logic       period_start;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  servo_pwm_array_if #(.NUM_CH(3), .ANG_W(10)) ang_if ();

  servo_pwm_array #(
    .CLK_FREQ(2000), .PWM_FREQ(1), .NUM_CH(3), .ANG_W(10), .ANG_MAX(270),
    .DC_MIN(250), .DC_MID(750), .DC_MAX(1250), .HYST(15), .SLEW_STEP(50)
  ) dut (
    .clk(clk), .rst(rst), .ang(ang_if), .enable(enable),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_flat(input int x, input int y, input int z);
    ang_if.ang_flat = {10'(z), 10'(y), 10'(x)};
  endtask

  // Counts busy cycles starting at the current negedge until ang_ready returns.
  task automatic count_busy(input string tag);
    int lo = 0;
    while (!ang_if.ang_ready && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    check(tag, lo, 3);
  endtask

  task automatic send(input int x, input int y, input int z);
    int n = 0;
    @(negedge clk);
    set_flat(x, y, z);
    ang_if.ang_valid = 1'b1;
    while (!ang_if.ang_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", ang_if.ang_ready, 1);
    @(negedge clk);
    ang_if.ang_valid = 1'b0;
    count_busy("ready_low");
  endtask

  // Measures high time per channel over the next full period.
  task automatic measure(input string tag, input int e0, input int e1, input int e2);
    int hi[3];
    int k = 0;
    int n = 0;
    @(negedge clk);
    while (!period_start && n < 3*PERIOD) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sync"}, period_start, 1);
    hi = '{0, 0, 0};
    do begin
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      @(negedge clk);
      k++;
    end while (!period_start && k < 3*PERIOD);
    check({tag, "_period"}, k, PERIOD);
    check({tag, "_ch0"}, hi[0], e0);
    check({tag, "_ch1"}, hi[1], e1);
    check({tag, "_ch2"}, hi[2], e2);
  endtask

  initial begin
    rst = 1'b1;
    enable = 3'b111;
    ang_if.ang_valid = 1'b0;
    set_flat(0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", ang_if.ang_ready, 1);
    check("rst_pwm", pwm_out, 0);
    check("rst_pstart", period_start, 0);
    rst = 1'b0;

`ifdef SERVO_SLEW_EN
    measure("slew_base", 750, 750, 750);
    send(270, 0, 0);
    for (int p = 1; p <= 10; p++) measure("slew_step", 750 + 50*p, 750, 750);
    measure("slew_hold", 1250, 750, 750);
`else
    measure("reset_mid", 750, 750, 750);

    send(270, -270, 0);
    measure("full_range", 1250, 250, 750);

    send(100, -270, 0);
    measure("hyst_100", 935, 250, 750);
    send(110, -270, 0);
    measure("hyst_110", 935, 250, 750);
    send(116, -270, 0);
    measure("hyst_116", 964, 250, 750);

    send(-512, -270, 0);
    measure("clamp_neg", 250, 250, 750);
    send(300, -270, 0);
    measure("clamp_pos", 1250, 250, 750);

    enable = 3'b110;
    measure("en0_off", 0, 250, 750);
    enable = 3'b111;

    // Valid held through CONV: second set accepted at T+4, committed at T+7.
    begin
      int n = 0;
      @(negedge clk);
      set_flat(-100, -270, 0);
      ang_if.ang_valid = 1'b1;
      while (!ang_if.ang_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_ready", ang_if.ang_ready, 1);
      @(negedge clk);
      set_flat(50, 100, -50);
      check("b2b_busy_t1", ang_if.ang_ready, 0);
      repeat (3) @(negedge clk);
      check("b2b_ready_t4", ang_if.ang_ready, 1);
      @(negedge clk);
      check("b2b_accept_t5", ang_if.ang_ready, 0);
      ang_if.ang_valid = 1'b0;
      count_busy("b2b_busy2");
    end
    measure("b2b_second", 842, 935, 658);

    // Reset during CONV discards pending work.
    begin
      int n = 0;
      @(negedge clk);
      set_flat(200, 200, 200);
      ang_if.ang_valid = 1'b1;
      while (!ang_if.ang_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      ang_if.ang_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", ang_if.ang_ready, 1);
      rst = 1'b0;
    end
    measure("abort_duty", 750, 750, 750);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
# servo_pwm_array

Parametrised multi-channel servo PWM generator for the robotic arm. It accepts a coherent set of signed angle setpoints through a valid/ready handshake and converts them sequentially to duty-cycle counts, applying clamping and per-channel hysteresis. All channels update together on a PWM period boundary, so pulses are never truncated or glitched. It sits between the joint-angle source (accelerometer/IK path) and the servo pins, and replaces the fixed three-channel generator.

## Interface
- CLK_FREQ, 25_000_000: clock frequency, Hz
- PWM_FREQ, 50: PWM frequency, Hz; PERIOD = CLK_FREQ/PWM_FREQ (500_000)
- NUM_CH, 3: channel count, 1..16
- ANG_W, 10: signed angle width per channel
- ANG_MAX, 270: clamp magnitude, degrees
- DC_MIN / DC_MID / DC_MAX, 25_000 / 75_000 / 125_000: duty counts at -ANG_MAX / 0 / +ANG_MAX; DC_MAX < PERIOD required
- HYST, 15: minimum angle change accepted, degrees
- SLEW_STEP, 5_000: maximum duty change per period (only with SERVO_SLEW_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ang_flat  in  NUM_CH*ANG_W  signed angles; channel i = bits [i*ANG_W +: ANG_W]
- ang_valid  in  1  setpoint set valid
- ang_ready  out  1  block can accept a set
- enable  in  NUM_CH  per-channel output enable
- pwm_out  out  NUM_CH  servo PWM, registered
- period_start  out  1  one-cycle pulse when the period counter is 0

## Operation
- Counter runs 0..PERIOD-1 and wraps. period_start = (counter==0), registered alongside pwm_out.
- pwm_out[i] = enable[i] && (counter < duty_act[i]). With enable[i] low, the output is held low and duty_act[i] still tracks commits.
- FSM states:
  - IDLE: ang_ready=1. On ang_valid&&ang_ready, latch ang_flat and go to CONV.
  - CONV: ang_ready=0. Converts one channel per cycle, ch 0..NUM_CH-1, into pending[i]. After the last channel, commit all pending to target[] in the same cycle and return to IDLE.
  - ang_valid in CONV is ignored; the source must hold it.
- Per-channel conversion:
  - Sign-extend to ANG_W+1 bits, then clamp to [-ANG_MAX, +ANG_MAX]. Most-negative input must not overflow.
  - If |a - last[i]| <= HYST: pending[i] = target[i] and last[i] is unchanged.
  - Otherwise: last[i] = a.
    - For a >= 0: pending = DC_MID + ((DC_MAX-DC_MID)*a)/ANG_MAX.
    - For a < 0: pending = DC_MID - ((DC_MID-DC_MIN)*|a|)/ANG_MAX.
  - Division truncates. Intermediates are 32-bit unsigned.
- duty_act[] loads from target[] only in the cycle counter==PERIOD-1, so all channels switch together. A commit in that same cycle is visible to that load.

## Timing
- Reset values:
  - pwm_out=0, period_start=0, ang_ready=1 (IDLE), counter=0
  - target=duty_act=DC_MID
  - last=0
- Handshake accepted in cycle T: ang_ready=0 for T+1..T+NUM_CH, commit at T+NUM_CH, ang_ready=1 at T+NUM_CH+1.
- New duty takes effect at the first counter wrap after the commit. pwm_out lags the counter by one cycle. High time is exactly duty_act cycles per period.
- Reset mid-CONV aborts: pending values are discarded and target/duty_act return to DC_MID.

## Configuration
- SERVO_SLEW_EN:
  - Defined: at each period load, duty_act[i] moves toward target[i] by at most SLEW_STEP, and never overshoots.
  - Undefined: duty_act[i] = target[i] directly, and the SLEW_STEP parameter is unused.

## Test plan
- Reset release, enable=3'b111 -> each channel high for 75_000 cycles per 500_000-cycle period; period_start pulses every 500_000 cycles.
- Load {z=0, y=-270, x=270} -> from the next wrap, ch0=125_000, ch1=25_000, ch2=75_000 high cycles; ang_ready low exactly 3 cycles.
- Hysteresis on ch0: load 100 -> 93_518; load 110 -> still 93_518; load 116 -> 96_481.
- Clamp: x=-512 -> 25_000; x=300 -> 125_000. enable[0]=0 -> pwm_out[0] stays 0.
- ang_valid held high through CONV -> second set accepted at T+4, committed at T+7. Reset asserted at T+2 -> all duties 75_000, ang_ready=1.
- SERVO_SLEW_EN defined, 75_000 -> 125_000 -> duty rises 80_000, 85_000, … and reaches 125_000 after 10 periods.
